// File: rtl/irq_arbiter.sv
// 16-source interrupt arbiter: edge capture into pending, masked highest-index
// selection, and a single-in-flight req/ack/done handshake with the CPU.
module irq_arbiter #(
    parameter logic [15:0] MASK_RST = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] irq_src,
    input  logic        mask_we,
    input  logic [15:0] mask_wdata,
    output logic [15:0] mask_q,
    output logic [15:0] pending_q,
    output logic        irq_req,
    output logic [3:0]  irq_id,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic        in_service
);

    localparam int unsigned N_SRC = 16;
    localparam int unsigned ID_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [N_SRC-1:0]  src_d;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  elig;
    logic [N_SRC-1:0]  clr;
    logic [N_SRC-1:0]  pending_d;
    logic [N_SRC-1:0]  mask_d;
    logic [ID_W-1:0]   sel;
    logic              req_d;
    logic [ID_W-1:0]   id_d;
    logic              svc_d;

    assign rise = irq_src & ~src_d;
    assign elig = pending_q & ~mask_q;

    // Highest set index wins; later iterations overwrite lower ones.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (elig[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        req_d   = irq_req;
        id_d    = irq_id;
        svc_d   = in_service;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = sel;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                    req_d   = 1'b0;
                    svc_d   = 1'b1;
                    clr     = N_SRC'(1) << irq_id;
                end else if (mask_q[irq_id]) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                    svc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                svc_d   = 1'b0;
            end
        endcase
    end

    // A fresh edge on the bit being acknowledged survives the clear.
    assign pending_d = (pending_q & ~clr) | rise;
    assign mask_d    = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_d      <= '0;
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_d      <= irq_src;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_req    <= req_d;
            irq_id     <= id_d;
            in_service <= svc_d;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios followed by random
// traffic compared every cycle against a behavioural model.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irq_src;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic [15:0] mask_q;
    logic [15:0] pending_q;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;
    logic        in_service;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: one in-flight interrupt, tracked by phase.
    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_HANDLER = 2;
    int          m_phase;
    logic [15:0] m_pend, m_mask, m_prev;
    logic        m_req, m_svc;
    int          m_id;

    irq_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_pend  = 16'h0000;
        m_mask  = 16'hFFFF;
        m_prev  = 16'h0000;
        m_req   = 1'b0;
        m_svc   = 1'b0;
        m_id    = 0;
    endtask

    function automatic int top_index(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [15:0] edges;
        logic [15:0] avail;
        logic [15:0] next_pend;
        edges     = irq_src & ~m_prev;
        avail     = m_pend & ~m_mask;
        next_pend = m_pend | edges;
        if (m_phase == PH_IDLE) begin
            if (avail != 0) begin
                m_phase = PH_WAIT;
                m_req   = 1'b1;
                m_id    = top_index(avail);
            end
        end else if (m_phase == PH_WAIT) begin
            if (irq_ack) begin
                if (!edges[m_id]) next_pend[m_id] = 1'b0;
                m_phase = PH_HANDLER;
                m_req   = 1'b0;
                m_svc   = 1'b1;
            end else if (m_mask[m_id]) begin
                m_phase = PH_IDLE;
                m_req   = 1'b0;
            end
        end else begin
            if (irq_done) begin
                m_phase = PH_IDLE;
                m_svc   = 1'b0;
            end
        end
        m_pend = next_pend;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_src;
    endtask

    // One clock: model follows the edge, DUT sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq_req", 32'(irq_req), 32'(m_req));
        check("in_service", 32'(in_service), 32'(m_svc));
        check("pending_q", 32'(pending_q), 32'(m_pend));
        check("mask_q", 32'(mask_q), 32'(m_mask));
        if (m_req) check("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic write_mask(input logic [15:0] v);
        mask_we = 1'b1; mask_wdata = v;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        irq_ack = 1'b0; irq_done = 1'b0;
        model_reset();
        #12;
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_svc", 32'(in_service), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pend", 32'(pending_q), 32'h0);
        check("rst_mask", 32'(mask_q), 32'hFFFF);
        rst_n = 1'b1;
        #4;

        // 1: single source, two-cycle latency
        write_mask(16'h0000);
        irq_src = 16'h0020;
        tick();
        check("t1_pend", 32'(pending_q), 32'h0020);
        check("t1_req_early", 32'(irq_req), 32'd0);
        tick();
        check("t1_req", 32'(irq_req), 32'd1);
        check("t1_id", 32'(irq_id), 32'd5);
        irq_src = '0;
        pulse_ack();
        pulse_done();

        // 2: simultaneous arrivals, highest index first, idle gap after done
        irq_src = 16'h1008;
        tick(); tick();
        check("t2_id12", 32'(irq_id), 32'd12);
        irq_src = '0;
        pulse_ack();
        pulse_done();
        check("t2_gap", 32'(irq_req), 32'd0);
        tick();
        check("t2_req3", 32'(irq_req), 32'd1);
        check("t2_id3", 32'(irq_id), 32'd3);
        pulse_ack();
        pulse_done();

        // 3: masked edge is captured, request appears once unmasked
        write_mask(16'hFFFF);
        irq_src = 16'h0080;
        tick(); tick();
        check("t3_pend", 32'(pending_q), 32'h0080);
        check("t3_noreq", 32'(irq_req), 32'd0);
        irq_src = '0;
        write_mask(16'hFF7F);
        tick();
        check("t3_req", 32'(irq_req), 32'd1);
        check("t3_id", 32'(irq_id), 32'd7);
        pulse_ack();
        pulse_done();

        // 4: no preemption of a latched request
        write_mask(16'h0000);
        irq_src = 16'h0010;
        tick(); tick();
        check("t4_id4", 32'(irq_id), 32'd4);
        irq_src = 16'h0200;
        tick();
        check("t4_frozen", 32'(irq_id), 32'd4);
        irq_src = '0;
        pulse_ack();
        check("t4_pend9", 32'(pending_q), 32'h0200);
        pulse_done();
        tick();
        check("t4_id9", 32'(irq_id), 32'd9);
        pulse_ack();
        pulse_done();

        // 5: masking the latched source withdraws the request
        irq_src = 16'h0004;
        tick(); tick();
        check("t5_id2", 32'(irq_id), 32'd2);
        irq_src = '0;
        write_mask(16'h0004);
        tick();
        check("t5_withdrawn", 32'(irq_req), 32'd0);
        check("t5_kept", 32'(pending_q), 32'h0004);
        pulse_done();
        check("t5_done_ign", 32'(in_service), 32'd0);
        write_mask(16'h0000);
        tick();
        check("t5_reissue", 32'(irq_id), 32'd2);
        pulse_ack();

        // 6: asynchronous reset while in service
        irq_src = 16'h0002;
        tick();
        check("t6_pre_svc", 32'(in_service), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_svc", 32'(in_service), 32'd0);
        check("t6_req", 32'(irq_req), 32'd0);
        check("t6_pend", 32'(pending_q), 32'h0);
        check("t6_mask", 32'(mask_q), 32'hFFFF);
        irq_src = '0;
        #1 rst_n = 1'b1;

        // Random traffic against the model
        write_mask(16'h0000);
        for (int c = 0; c < 4000; c++) begin
            irq_src ^= 16'($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 16'($urandom & $urandom);
            if (m_req) irq_ack = ($urandom_range(0, 1) == 1);
            else       irq_ack = ($urandom_range(0, 15) == 0);
            if (m_svc) irq_done = ($urandom_range(0, 2) == 0);
            else       irq_done = ($urandom_range(0, 15) == 0);
            tick();
        end
        mask_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
